// File: rtl/sat_accum_16bit_pkg.sv
// Shared types and constants for the saturating accumulator.
package sat_pkg;

    typedef enum logic {ACC, DONE} sat_state_t;

    localparam int unsigned DATA_W = 16;
    localparam logic [15:0] SAT_MAX = 16'h7FFF;
    localparam logic [15:0] SAT_MIN = 16'h8000;

endpackage

// File: rtl/sat_accum_16bit_if.sv
// Operand stream in, result stream out; slave is the accumulator's view.
interface sat_accum_16bit_if #(parameter int CNT_W = 8);
    import sat_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_sub;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_sat;
    logic [CNT_W-1:0]  out_count;

    modport slave (
        input  in_valid, in_data, in_sub, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sat, out_count
    );

    modport master (
        output in_valid, in_data, in_sub, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sat, out_count
    );

endinterface

// File: rtl/sat_accum_16bit_addsub.sv
// Combinational signed 16-bit add/sub with exact 17-bit result clamped to range.
module sat_addsub16
    import sat_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] sum,
    output logic              ovfl
);

    logic [DATA_W:0] ax;
    logic [DATA_W:0] bx;
    logic [DATA_W:0] r;

    always_comb begin
        ax = {a[DATA_W-1], a};
        bx = {b[DATA_W-1], b};
        r  = sub ? (ax - bx) : (ax + bx);
        // 17-bit result fits in 16 bits only when the top two bits agree
        ovfl = r[DATA_W] ^ r[DATA_W-1];
        if (!ovfl)
            sum = r[DATA_W-1:0];
        else if (r[DATA_W])
            sum = SAT_MIN;
        else
            sum = SAT_MAX;
    end

endmodule

// File: rtl/sat_accum_16bit.sv
// Packet accumulator: folds each operand beat into a clamped running sum and
// emits one result (sum, sticky saturation, beat count) per packet.
module sat_accum_16bit
    import sat_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    sat_accum_16bit_if.slave    bus
);

    sat_state_t        state;
    logic [DATA_W-1:0] acc;
    logic              sat;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] sum;
    logic              ovfl;
    logic              xfer;

    sat_addsub16 u_addsub (
        .a    (acc),
        .b    (bus.in_data),
        .sub  (bus.in_sub),
        .sum  (sum),
        .ovfl (ovfl)
    );

    // rst_n gates ready so nothing is advertised while reset is held
    assign bus.in_ready  = rst_n & (state == ACC) & ~clr;
    assign xfer          = bus.in_valid & bus.in_ready;

    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = acc;
    assign bus.out_sat   = sat;
    assign bus.out_count = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
            acc   <= '0;
            sat   <= 1'b0;
            cnt   <= '0;
        end else if (clr) begin
            state <= ACC;
            acc   <= '0;
            sat   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (xfer) begin
                        acc <= sum;
                        sat <= sat | ovfl;
                        if (cnt != '1)
                            cnt <= cnt + CNT_W'(1);
                        if (bus.in_last)
                            state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= ACC;
                        acc   <= '0;
                        sat   <= 1'b0;
                        cnt   <= '0;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule
